// File: rtl/ws2812_frame_ctl_if.sv
// rtl/ws2812_frame_ctl_if.sv - frame controller handshake bundle: host start/status, pixel RAM read, bit serializer.
interface ws2812_frame_ctl_if;
    logic        frame_start_in;
    logic [7:0]  ram_rd_addr_out;
    logic [23:0] ram_rd_data_in;
    logic        bit_rdy_out;
    logic        bit_data_out;
    logic        bit_done_in;
    logic        busy_out;
    logic        frame_done_out;
    logic        timeout_out;

    modport master (
        input  frame_start_in,
        input  ram_rd_data_in,
        input  bit_done_in,
        output ram_rd_addr_out,
        output bit_rdy_out,
        output bit_data_out,
        output busy_out,
        output frame_done_out,
        output timeout_out
    );

    modport slave (
        output frame_start_in,
        output ram_rd_data_in,
        output bit_done_in,
        input  ram_rd_addr_out,
        input  bit_rdy_out,
        input  bit_data_out,
        input  busy_out,
        input  frame_done_out,
        input  timeout_out
    );
endinterface

// File: rtl/ws2812_frame_ctl.sv
// rtl/ws2812_frame_ctl.sv - WS2812 frame sequencer: reads GRB pixels from RAM and feeds them MSB-first to a bit serializer.
module ws2812_frame_ctl #(
    parameter logic [8:0]  LED_NUM     = 9'd64,
    parameter logic [15:0] CNT_LATCH   = 16'd60000,
    parameter logic [9:0]  CNT_TIMEOUT = 10'd1023
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    ws2812_frame_ctl_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        WAIT  = 3'd4,
        LATCH = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  pix_idx;
    logic [23:0] shreg;
    logic [4:0]  bit_cnt;
    logic [9:0]  to_cnt;
    logic [15:0] latch_cnt;
    logic        busy;
    logic        timeout;
    logic        last_pix;
    logic        to_expire;

    assign last_pix  = (pix_idx == LED_NUM - 9'd1);
    assign to_expire = (to_cnt == CNT_TIMEOUT - 10'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.frame_start_in) state_nxt = READ;
            READ:  state_nxt = LOAD;
            LOAD:  state_nxt = SEND;
            SEND:  state_nxt = WAIT;
            WAIT: begin
                // a done arriving on the expiry cycle still counts as a completed bit
                if (bus.bit_done_in) begin
                    if (bit_cnt != 5'd0)
                        state_nxt = SEND;
                    else if (last_pix)
                        state_nxt = LATCH;
                    else
                        state_nxt = READ;
                end else if (to_expire) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: if (latch_cnt == CNT_LATCH - 16'd1) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            pix_idx   <= 9'd0;
            shreg     <= 24'd0;
            bit_cnt   <= 5'd0;
            to_cnt    <= 10'd0;
            latch_cnt <= 16'd0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.frame_start_in) begin
                        pix_idx <= 9'd0;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                    end
                end
                LOAD: begin
                    shreg   <= bus.ram_rd_data_in;
                    bit_cnt <= 5'd23;
                end
                WAIT: begin
                    if (bus.bit_done_in) begin
                        shreg <= {shreg[22:0], 1'b0};
                        if (bit_cnt != 5'd0)
                            bit_cnt <= bit_cnt - 5'd1;
                        else if (!last_pix)
                            pix_idx <= pix_idx + 9'd1;
                    end else if (to_expire) begin
                        timeout <= 1'b1;
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
            // counters only run in their own state, so each entry starts from zero
            to_cnt    <= (state == WAIT && !bus.bit_done_in) ? to_cnt + 10'd1 : 10'd0;
            latch_cnt <= (state == LATCH) ? latch_cnt + 16'd1 : 16'd0;
        end
    end

    assign bus.ram_rd_addr_out = pix_idx[7:0];
    assign bus.bit_rdy_out     = (state == SEND);
    assign bus.bit_data_out    = (state == SEND || state == WAIT) ? shreg[23] : 1'b0;
    assign bus.busy_out        = busy;
    assign bus.frame_done_out  = (state == DONE);
    assign bus.timeout_out     = timeout;

endmodule

// File: tb/tb_ws2812_frame_ctl.sv
// tb/tb_ws2812_frame_ctl.sv - self-checking bench for ws2812_frame_ctl.
module tb_ws2812_frame_ctl;

    localparam int LAT = 100;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    ws2812_frame_ctl_if bus ();
    ws2812_frame_ctl_if bus1 ();

    ws2812_frame_ctl #(.LED_NUM(9'd2), .CNT_LATCH(16'd100), .CNT_TIMEOUT(10'd1023)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));
    ws2812_frame_ctl #(.LED_NUM(9'd1), .CNT_LATCH(16'd100), .CNT_TIMEOUT(10'd1023)) dut1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus1));

    int total = 0;
    int bad = 0;

    logic [23:0] ram [0:1];
    always @(posedge clk_in) bus.ram_rd_data_in <= ram[bus.ram_rd_addr_out[0]];
    always @(posedge clk_in) bus1.ram_rd_data_in <= (bus1.ram_rd_addr_out == 8'd0) ? 24'hFFFFFF : 24'h000000;

    // serializer model + monitor for the two-pixel instance; ser_dly 0 means never answer
    int   ser_dly = 1;
    int   rem = 0;
    logic spur = 1'b0;
    logic ser_done;
    int   rdy_cnt, fd_cnt, busy_cyc, stab_bad, addr_bad;
    logic bits [$];

    always @(negedge clk_in) begin
        ser_done = 1'b0;
        if (rem > 0) begin
            rem--;
            if (rem == 0) ser_done = 1'b1;
        end
        if (bus.bit_rdy_out && ser_dly > 0) rem = ser_dly;
        bus.bit_done_in = ser_done | spur;
        if (bus.bit_rdy_out) begin
            rdy_cnt++;
            bits.push_back(bus.bit_data_out);
        end
        if (ser_done && bits.size() > 0 && bus.bit_data_out !== bits[$]) stab_bad++;
        if (bus.frame_done_out) fd_cnt++;
        if (bus.busy_out) busy_cyc++;
        if (bus.ram_rd_addr_out > 8'd1) addr_bad++;
    end

    int rem1 = 0;
    logic sd1;
    int rdy1 = 0, ones1 = 0, fd1 = 0, busy1 = 0, addr1_bad = 0;
    always @(negedge clk_in) begin
        sd1 = 1'b0;
        if (rem1 > 0) begin
            rem1--;
            if (rem1 == 0) sd1 = 1'b1;
        end
        if (bus1.bit_rdy_out) begin
            rem1 = 2;
            rdy1++;
            if (bus1.bit_data_out === 1'b1) ones1++;
        end
        bus1.bit_done_in = sd1;
        if (bus1.frame_done_out) fd1++;
        if (bus1.busy_out) busy1++;
        if (bus1.ram_rd_addr_out != 8'd0) addr1_bad++;
    end

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        int          dly;
        logic [47:0] exp_bits;
        int          exp_busy;
    } vec_t;
    vec_t tbl [7];

    function automatic int model_busy(int n, int d);
        return n * (2 + 24 * (1 + d)) + LAT + 1;
    endfunction

    function automatic logic [47:0] packed_bits();
        logic [47:0] v = '0;
        for (int i = 0; i < 48; i++) v[47 - i] = (i < bits.size()) ? bits[i] : 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_mon();
        rdy_cnt = 0; fd_cnt = 0; busy_cyc = 0; stab_bad = 0; addr_bad = 0;
        bits.delete();
    endtask

    task automatic pulse_start();
        step();
        bus.frame_start_in = 1'b1;
        step();
        bus.frame_start_in = 1'b0;
    endtask

    task automatic spur_pulse();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
    endtask

    task automatic wait_fd(input int budget);
        int n = 0;
        while (fd_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk("frame_done_seen", 64'(fd_cnt != 0), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr"},    64'(bus.ram_rd_addr_out), 64'd0);
        chk({tag, "_rdy"},     64'(bus.bit_rdy_out),     64'd0);
        chk({tag, "_data"},    64'(bus.bit_data_out),    64'd0);
        chk({tag, "_busy"},    64'(bus.busy_out),        64'd0);
        chk({tag, "_done"},    64'(bus.frame_done_out),  64'd0);
        chk({tag, "_timeout"}, 64'(bus.timeout_out),     64'd0);
    endtask

    initial begin
        int n;
        bus.frame_start_in  = 1'b0;
        bus1.frame_start_in = 1'b0;

        tbl[0] = '{24'hA50000, 24'h00000F, 340, 48'hA5000000000F, 16473};
        tbl[1] = '{24'hFFFFFF, 24'h000000, 1, 48'hFFFFFF000000, 201};
        tbl[2] = '{24'h123456, 24'h800001, 3, 48'h123456800001, 297};
        for (int i = 3; i < 7; i++) begin
            tbl[i].p0       = 24'($urandom);
            tbl[i].p1       = 24'($urandom);
            tbl[i].dly      = int'($urandom_range(1, 9));
            tbl[i].exp_bits = {tbl[i].p0, tbl[i].p1};
            tbl[i].exp_busy = model_busy(2, tbl[i].dly);
        end

        rst_n_in = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst_n_in = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            ram[0] = tbl[i].p0;
            ram[1] = tbl[i].p1;
            ser_dly = tbl[i].dly;
            clear_mon();
            pulse_start();
            wait_fd(tbl[i].exp_busy + 50);
            repeat (5) step();
            chk($sformatf("v%0d_rdy_count", i), 64'(rdy_cnt), 64'd48);
            chk($sformatf("v%0d_bits", i), 64'(packed_bits()), 64'(tbl[i].exp_bits));
            chk($sformatf("v%0d_busy_cycles", i), 64'(busy_cyc), 64'(tbl[i].exp_busy));
            chk($sformatf("v%0d_frame_done", i), 64'(fd_cnt), 64'd1);
            chk($sformatf("v%0d_timeout", i), 64'(bus.timeout_out), 64'd0);
            chk($sformatf("v%0d_bit_stable", i), 64'(stab_bad), 64'd0);
            chk($sformatf("v%0d_addr_range", i), 64'(addr_bad), 64'd0);
        end

        // second start while the first frame is still sending
        ram[0] = 24'($urandom);
        ram[1] = 24'($urandom);
        ser_dly = 5;
        clear_mon();
        pulse_start();
        repeat (10) step();
        pulse_start();
        wait_fd(model_busy(2, 5) + 50);
        repeat (model_busy(2, 5) + 50) step();
        chk("restart_frame_done", 64'(fd_cnt), 64'd1);
        chk("restart_rdy_count", 64'(rdy_cnt), 64'd48);
        chk("restart_busy_cycles", 64'(busy_cyc), 64'(model_busy(2, 5)));
        chk("restart_bits", 64'(packed_bits()), 64'({ram[0], ram[1]}));

        // serializer never answers
        ser_dly = 0;
        clear_mon();
        pulse_start();
        wait_fd(1300);
        repeat (5) step();
        chk("to_flag", 64'(bus.timeout_out), 64'd1);
        chk("to_rdy_count", 64'(rdy_cnt), 64'd1);
        chk("to_busy_cycles", 64'(busy_cyc), 64'd1127);
        ser_dly = 1;
        clear_mon();
        pulse_start();
        chk("to_cleared_on_start", 64'(bus.timeout_out), 64'd0);
        chk("to_busy_on_start", 64'(bus.busy_out), 64'd1);
        wait_fd(400);
        repeat (3) step();
        chk("to_stays_clear", 64'(bus.timeout_out), 64'd0);

        // reset during bit 10 of pixel 0
        ser_dly = 4;
        clear_mon();
        pulse_start();
        n = 0;
        while (rdy_cnt < 11 && n < 500) begin
            step();
            n++;
        end
        chk("rst_reached_bit10", 64'(rdy_cnt), 64'd11);
        rst_n_in = 1'b0;
        step();
        check_idle_outputs("midrst");
        rst_n_in = 1'b1;
        step();
        chk("midrst_no_rdy_after", 64'(bus.bit_rdy_out), 64'd0);
        repeat (300) step();
        chk("midrst_no_frame_done", 64'(fd_cnt), 64'd0);
        chk("midrst_no_more_rdy", 64'(rdy_cnt), 64'd11);

        // stray bit_done in IDLE, then in LATCH
        clear_mon();
        spur_pulse();
        repeat (5) step();
        chk("spur_idle_rdy", 64'(rdy_cnt), 64'd0);
        chk("spur_idle_busy", 64'(bus.busy_out), 64'd0);
        ser_dly = 1;
        clear_mon();
        pulse_start();
        n = 0;
        while (rdy_cnt < 48 && n < 400) begin
            step();
            n++;
        end
        repeat (20) step();
        spur_pulse();
        wait_fd(400);
        repeat (3) step();
        chk("spur_latch_rdy", 64'(rdy_cnt), 64'd48);
        chk("spur_latch_busy_cycles", 64'(busy_cyc), 64'(model_busy(2, 1)));
        chk("spur_latch_frame_done", 64'(fd_cnt), 64'd1);

        // single-pixel instance
        step();
        bus1.frame_start_in = 1'b1;
        step();
        bus1.frame_start_in = 1'b0;
        n = 0;
        while (fd1 == 0 && n < 500) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("one_rdy_count", 64'(rdy1), 64'd24);
        chk("one_ones", 64'(ones1), 64'd24);
        chk("one_addr_zero", 64'(addr1_bad), 64'd0);
        chk("one_frame_done", 64'(fd1), 64'd1);
        chk("one_busy_cycles", 64'(busy1), 64'(model_busy(1, 2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
